// File: rtl/alu_reservation_station_pkg.sv
// Shared types, sizing constants and the CDB wakeup helper for the integer ALU
// reservation station.
package alu_reservation_station_pkg;
    localparam int RS_DEPTH = 8;
    localparam int ALU_SIZE = 2;
    localparam int CDB_SIZE = 2;
    localparam int TAG_W    = 4;
    localparam int XLEN     = 32;
    localparam int OP_W     = 4;
    localparam int IDX_W    = $clog2(RS_DEPTH);
    localparam int CNT_W    = $clog2(RS_DEPTH) + 1;

    typedef logic [OP_W-1:0]  alu_op_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  word_t;

    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        word_t val;
    } rs_src_t;

    typedef struct packed {
        logic    valid;
        alu_op_t op;
        tag_t    dst_tag;
        rs_src_t src1;
        rs_src_t src2;
    } rs_entry_t;

    // Applies any matching CDB broadcast to a waiting source; the lowest port wins.
    function automatic rs_src_t wake_src(
        input rs_src_t                    src,
        input logic  [CDB_SIZE-1:0]       cdbValid,
        input tag_t  [CDB_SIZE-1:0]       cdbTag,
        input word_t [CDB_SIZE-1:0]       cdbVal
    );
        rs_src_t res;
        res = src;
        if (!src.rdy) begin
            for (int p = CDB_SIZE - 1; p >= 0; p--) begin
                if (cdbValid[p] && (cdbTag[p] == src.tag)) begin
                    res.rdy = 1'b1;
                    res.val = cdbVal[p];
                end
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/alu_reservation_station_pick.sv
// Lowest-index find-first over req_i with the bits in mask_i excluded.
module rs_priority_pick #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [N-1:0] avail;

    assign avail = req_i & ~mask_i;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (avail[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/alu_reservation_station.sv
// Unified reservation station for the integer ALUs: captures operands from the CDB
// and issues ready entries to idle ALUs, lowest entry index first.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  alu_op_t                   disp_op_i,
    input  tag_t                      disp_dst_tag_i,
    input  logic                      disp_src1_rdy_i,
    input  logic                      disp_src2_rdy_i,
    input  tag_t                      disp_src1_tag_i,
    input  tag_t                      disp_src2_tag_i,
    input  word_t                     disp_src1_val_i,
    input  word_t                     disp_src2_val_i,
    input  logic    [CDB_SIZE-1:0]    cdb_valid_i,
    input  tag_t    [CDB_SIZE-1:0]    cdb_tag_i,
    input  word_t   [CDB_SIZE-1:0]    cdb_val_i,
    input  logic    [ALU_SIZE-1:0]    alu_busy_i,
    output logic    [ALU_SIZE-1:0]    iss_valid_o,
    output alu_op_t [ALU_SIZE-1:0]    iss_op_o,
    output tag_t    [ALU_SIZE-1:0]    iss_dst_tag_o,
    output word_t   [ALU_SIZE-1:0]    iss_src1_o,
    output word_t   [ALU_SIZE-1:0]    iss_src2_o,
    output logic    [CNT_W-1:0]       free_count_o
);
    rs_entry_t           entries_q [RS_DEPTH];
    rs_entry_t           entries_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] validVec;
    logic [RS_DEPTH-1:0] issuableVec;
    logic [RS_DEPTH-1:0] issueMask;
    logic                allocFound;
    logic [IDX_W-1:0]    allocIdx;
    rs_src_t             dispSrc1;
    rs_src_t             dispSrc2;

    // Issue eligibility looks only at registered ready bits, so a wakeup is seen next cycle.
    always_comb begin
        validVec    = '0;
        issuableVec = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            validVec[e]    = entries_q[e].valid;
            issuableVec[e] = entries_q[e].valid & entries_q[e].src1.rdy & entries_q[e].src2.rdy;
        end
    end

    always_comb begin
        free_count_o = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (!validVec[e]) begin
                free_count_o = free_count_o + CNT_W'(1);
            end
        end
    end

    assign disp_ready_o = (free_count_o != '0);

    rs_priority_pick #(.N(RS_DEPTH)) u_alloc (
        .req_i   (~validVec),
        .mask_i  ({RS_DEPTH{1'b0}}),
        .found_o (allocFound),
        .idx_o   (allocIdx)
    );

    // Each ALU picks after the lower-numbered ALUs, skipping entries they already claimed.
    for (genvar a = 0; a < ALU_SIZE; a++) begin : g_sel
        logic [RS_DEPTH-1:0] maskIn;
        logic [RS_DEPTH-1:0] maskOut;
        logic                found;
        logic                grant;
        logic [IDX_W-1:0]    idx;

        if (a == 0) begin : g_first
            assign maskIn = '0;
        end else begin : g_chain
            assign maskIn = g_sel[a-1].maskOut;
        end

        rs_priority_pick #(.N(RS_DEPTH)) u_pick (
            .req_i   (issuableVec),
            .mask_i  (maskIn),
            .found_o (found),
            .idx_o   (idx)
        );

        assign grant            = found & ~alu_busy_i[a] & ~flush_i;
        assign maskOut          = maskIn | (grant ? (RS_DEPTH'(1) << idx) : '0);
        assign iss_valid_o[a]   = grant;
        assign iss_op_o[a]      = grant ? entries_q[idx].op       : '0;
        assign iss_dst_tag_o[a] = grant ? entries_q[idx].dst_tag  : '0;
        assign iss_src1_o[a]    = grant ? entries_q[idx].src1.val : '0;
        assign iss_src2_o[a]    = grant ? entries_q[idx].src2.val : '0;
    end

    assign issueMask = g_sel[ALU_SIZE-1].maskOut;
    assign dispSrc1  = '{rdy: disp_src1_rdy_i, tag: disp_src1_tag_i, val: disp_src1_val_i};
    assign dispSrc2  = '{rdy: disp_src2_rdy_i, tag: disp_src2_tag_i, val: disp_src2_val_i};

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            entries_d[e] = entries_q[e];
            if (entries_q[e].valid) begin
                entries_d[e].src1 = wake_src(entries_q[e].src1, cdb_valid_i, cdb_tag_i, cdb_val_i);
                entries_d[e].src2 = wake_src(entries_q[e].src2, cdb_valid_i, cdb_tag_i, cdb_val_i);
            end
            if (issueMask[e]) begin
                entries_d[e].valid = 1'b0;
            end
        end
        // The allocated slot is invalid now, so it never collides with an issuing entry.
        if (disp_valid_i && allocFound) begin
            entries_d[allocIdx].valid   = 1'b1;
            entries_d[allocIdx].op      = disp_op_i;
            entries_d[allocIdx].dst_tag = disp_dst_tag_i;
            entries_d[allocIdx].src1    = wake_src(dispSrc1, cdb_valid_i, cdb_tag_i, cdb_val_i);
            entries_d[allocIdx].src2    = wake_src(dispSrc2, cdb_valid_i, cdb_tag_i, cdb_val_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                entries_q[e] <= entries_d[e];
            end
        end
    end
endmodule
